// File: rtl/md_audio_mixer_pkg.sv
// Shared widths, PCM limits and helpers for the MD audio mixer.
package md_audio_pkg;
  localparam int FM_W  = 9;
  localparam int ACC_W = 13;
  localparam int MIX_W = 19;
  localparam int PCM_W = 16;
  localparam int NCH   = 2;   // lane 0 = left, lane 1 = right
  localparam int CNT_W = 4;
  localparam int LPF_W = 20;  // 16 integer + 4 fraction bits

  typedef logic signed [PCM_W-1:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7FFF;
  localparam pcm_t PCM_MIN = 16'sh8000;

  function automatic logic [ACC_W-1:0] sext_fm(input logic [FM_W-1:0] x);
    return {{(ACC_W-FM_W){x[FM_W-1]}}, x};
  endfunction
endpackage

// File: rtl/md_audio_mixer_if.sv
// FM/PSG input bus and stereo PCM output bus of the MD audio mixer.
interface md_audio_mixer_if;
  import md_audio_pkg::*;

  logic [FM_W-1:0] MOL;
  logic [FM_W-1:0] MOR;
  logic            FM_SLOT;
  logic            FM_SYNC;
  logic [15:0]     PSG;
  pcm_t            AUD_L;
  pcm_t            AUD_R;
  logic            AUD_VALID;
  logic            FRAME_ERR;

  modport master (output MOL, MOR, FM_SLOT, FM_SYNC, PSG,
                  input  AUD_L, AUD_R, AUD_VALID, FRAME_ERR);
  modport slave  (input  MOL, MOR, FM_SLOT, FM_SYNC, PSG,
                  output AUD_L, AUD_R, AUD_VALID, FRAME_ERR);
endinterface

// File: rtl/md_audio_mixer_sat.sv
// Combinational clamp of a MIX_W-bit signed mix into signed 16-bit PCM.
module md_audio_sat
  import md_audio_pkg::*;
(
  input  logic [MIX_W-1:0] mix_i,
  output pcm_t             pcm_o
);
  logic in_range;

  // In range when every bit above the PCM sign bit equals the sign.
  assign in_range = (mix_i[MIX_W-1:PCM_W-1] == '0) || (mix_i[MIX_W-1:PCM_W-1] == '1);

  always_comb begin
    pcm_o = pcm_t'(mix_i[PCM_W-1:0]);
    if (!in_range) pcm_o = mix_i[MIX_W-1] ? PCM_MIN : PCM_MAX;
  end
endmodule

// File: rtl/md_audio_mixer.sv
// FM channel accumulator + PSG mixer emitting one stereo PCM sample per FM cycle.
// Define MD_AUDIO_LPF_EN to add a one-pole IIR low-pass stage (latency 3 instead of 2).
module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int FM_SLOTS  = 6,
  parameter int FM_SHIFT  = 4,
  parameter int PSG_SHIFT = 2,
  parameter int LPF_SHIFT = 3
)(
  input  logic              MCLK,
  input  logic              RESET,
  md_audio_mixer_if.slave   aud
);
`ifdef MD_AUDIO_LPF_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  if (FM_SLOTS < 1 || FM_SLOTS > 15) begin : g_bad_slots
    $error("FM_SLOTS must be 1..15");
  end
  if (LPF_SHIFT < 1 || LPF_SHIFT > 15) begin : g_bad_lpf
    $error("LPF_SHIFT must be 1..15");
  end

  logic [NCH-1:0][FM_W-1:0]  fm_in;
  logic [NCH-1:0][ACC_W-1:0] acc_q, acc_d, done_q, done_d;
  logic [NCH-1:0][MIX_W-1:0] mix_q, mix_d;
  logic [NCH-1:0][PCM_W-1:0] sat, sat_q, out;
  logic [15:0]               psg_q, psg_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      primed_q, primed_d, ferr_q, ferr_d, req;
  logic [STAGES:0]           vld_pipe_q;

  assign fm_in = {aud.MOR, aud.MOL};

  always_comb begin
    acc_d    = acc_q;
    done_d   = done_q;
    psg_d    = psg_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    ferr_d   = ferr_q;
    req      = 1'b0;
    if (aud.FM_SLOT) begin
      if (aud.FM_SYNC) begin
        // Sync slot closes the previous cycle and opens the new one with its own sample.
        done_d = acc_q;
        for (int c = 0; c < NCH; c++) acc_d[c] = sext_fm(fm_in[c]);
        psg_d = aud.PSG;
        if (primed_q && cnt_q != CNT_W'(FM_SLOTS)) ferr_d = 1'b1;
        cnt_d    = CNT_W'(1);
        primed_d = 1'b1;
        req      = primed_q;
      end else begin
        for (int c = 0; c < NCH; c++) acc_d[c] = acc_q[c] + sext_fm(fm_in[c]);
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign mix_d[c] = ({{(MIX_W-ACC_W){done_q[c][ACC_W-1]}}, done_q[c]} << FM_SHIFT)
                    + {3'b000, psg_q >> PSG_SHIFT};
    md_audio_sat u_sat (.mix_i(mix_q[c]), .pcm_o(sat[c]));
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      acc_q      <= '0;
      done_q     <= '0;
      psg_q      <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      ferr_q     <= 1'b0;
      mix_q      <= '0;
      sat_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      done_q     <= done_d;
      psg_q      <= psg_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      ferr_q     <= ferr_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], req};
      if (vld_pipe_q[0]) mix_q <= mix_d;
      if (vld_pipe_q[1]) sat_q <= sat;
    end
  end

`ifdef MD_AUDIO_LPF_EN
  logic [NCH-1:0][LPF_W-1:0] y_q, y_d;

  for (genvar c = 0; c < NCH; c++) begin : g_lpf
    logic [LPF_W:0] diff;
    // One extra bit: a full-scale swing of a 20-bit state needs 21 bits.
    assign diff   = {sat_q[c][PCM_W-1], sat_q[c], 4'b0000} - {y_q[c][LPF_W-1], y_q[c]};
    assign y_d[c] = y_q[c] + LPF_W'($signed(diff) >>> LPF_SHIFT);
    assign out[c] = y_q[c][LPF_W-1 -: PCM_W];
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)              y_q <= '0;
    else if (vld_pipe_q[2]) y_q <= y_d;
  end
`else
  assign out = sat_q;
`endif

  assign aud.AUD_L     = out[0];
  assign aud.AUD_R     = out[1];
  assign aud.AUD_VALID = vld_pipe_q[STAGES];
  assign aud.FRAME_ERR = ferr_q;
endmodule

// File: tb/tb_md_audio_mixer.sv
// Directed bench for md_audio_mixer with a frame-level reference model and per-cycle compare.
module tb_md_audio_mixer;
  logic MCLK = 1'b0;
  logic RESET;
  md_audio_mixer_if bus ();

  md_audio_mixer dut (.MCLK(MCLK), .RESET(RESET), .aud(bus));

  always #5 MCLK = ~MCLK;

`ifdef MD_AUDIO_LPF_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct { int due; int l; int r; } samp_t;

  int    tests = 0, fails = 0, cyc = 0;
  samp_t expq[$];
  int    sum_l, sum_r, nslots, hold_l, hold_r, y_l, y_r;
  bit    primed, ferr;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    expq.delete();
    sum_l = 0; sum_r = 0; nslots = 0;
    hold_l = 0; hold_r = 0; y_l = 0; y_r = 0;
    primed = 0; ferr = 0;
  endtask

  // Frame-level model: a sync closes the running frame and schedules its sample.
  task automatic model_slot(input int mol, input int mor, input bit sync, input int psg);
    samp_t s;
    if (sync) begin
      if (primed) begin
        if (nslots != 6) ferr = 1;
        s.due = cyc + 1 + LAT;
        s.l   = clamp16(sum_l * 16 + psg / 4);
        s.r   = clamp16(sum_r * 16 + psg / 4);
        expq.push_back(s);
      end
      primed = 1; sum_l = mol; sum_r = mor; nslots = 1;
    end else begin
      sum_l += mol; sum_r += mor; nslots++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge MCLK);
      bus.FM_SLOT = 0; bus.FM_SYNC = 0;
      @(posedge MCLK);
    end
  endtask

  task automatic slot(input int mol, input int mor, input bit sync, input int psg);
    @(negedge MCLK);
    bus.MOL = 9'(mol); bus.MOR = 9'(mor);
    bus.FM_SLOT = 1; bus.FM_SYNC = sync; bus.PSG = 16'(psg);
    @(posedge MCLK);
    model_slot(mol, mor, sync, psg);
    idle(1);
  endtask

  task automatic frame(input int n, input int mol, input int mor, input int psg);
    slot(mol, mor, 1, psg);
    repeat (n - 1) slot(mol, mor, 0, psg);
  endtask

  task automatic sync_noslot(input int mol, input int mor);
    @(negedge MCLK);
    bus.MOL = 9'(mol); bus.MOR = 9'(mor);
    bus.FM_SLOT = 0; bus.FM_SYNC = 1;
    @(posedge MCLK);
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    RESET = 1; bus.FM_SLOT = 0; bus.FM_SYNC = 0;
    model_reset();
    repeat (3) @(negedge MCLK);
    RESET = 0;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    chk(name, act, exp);
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the edge.
  always @(posedge MCLK) begin
    bit    expv;
    samp_t e;
    #1;
    cyc++;
    expv = (expq.size() > 0) && (expq[0].due == cyc);
    if (expv) begin
      e = expq.pop_front();
`ifdef MD_AUDIO_LPF_EN
      y_l += (e.l * 16 - y_l) >>> 3;
      y_r += (e.r * 16 - y_r) >>> 3;
      hold_l = y_l >>> 4;
      hold_r = y_r >>> 4;
`else
      hold_l = e.l;
      hold_r = e.r;
`endif
    end
    chk("aud_valid", int'(bus.AUD_VALID), int'(expv));
    chk("aud_l", int'(bus.AUD_L), hold_l);
    chk("aud_r", int'(bus.AUD_R), hold_r);
    chk("frame_err", int'(bus.FRAME_ERR), int'(ferr));
  end

  initial begin
    RESET = 1;
    bus.MOL = 0; bus.MOR = 0; bus.FM_SLOT = 0; bus.FM_SYNC = 0; bus.PSG = 0;
    model_reset();
    repeat (3) @(negedge MCLK);
    RESET = 0;
    #1;
    lit("reset_l", int'(bus.AUD_L), 0);
    lit("reset_valid", int'(bus.AUD_VALID), 0);
    lit("reset_ferr", int'(bus.FRAME_ERR), 0);

    frame(6, 10, 10, 0);
    idle(4); #1;
    lit("first_sync_silent", int'(bus.AUD_L), 0);

    frame(6, 255, -256, 0);
    idle(4); #1;
`ifdef MD_AUDIO_LPF_EN
    lit("lpf_step1_l", int'(bus.AUD_L), 120);
`else
    lit("mix960_l", int'(bus.AUD_L), 960);
    lit("mix960_r", int'(bus.AUD_R), 960);
`endif
    lit("ferr_clean", int'(bus.FRAME_ERR), 0);

    frame(6, 0, 0, 16'hFFFF);
    idle(4); #1;
`ifndef MD_AUDIO_LPF_EN
    lit("sat_pos_l", int'(bus.AUD_L), 32767);
    lit("psg_r", int'(bus.AUD_R), -8193);
`endif

    frame(4, 1, 2, 0);
    frame(6, 3, 3, 0);
    idle(4); #1;
    lit("short_ferr", int'(bus.FRAME_ERR), 1);
`ifndef MD_AUDIO_LPF_EN
    lit("short_l", int'(bus.AUD_L), 64);
    lit("short_r", int'(bus.AUD_R), 128);
`endif

    frame(6, -5, -5, 0);
    idle(4); #1;
    lit("ferr_sticky", int'(bus.FRAME_ERR), 1);

    slot(7, 7, 1, 0);
    slot(7, 7, 1, 0);
    slot(7, 7, 1, 0);
    idle(4); #1;
`ifndef MD_AUDIO_LPF_EN
    lit("b2b_l", int'(bus.AUD_L), 112);
`endif

    sync_noslot(50, 50);
    idle(2);
    frame(6, 1, 1, 0);
    idle(4);

    slot(9, 9, 1, 100);
    do_reset();
    #1;
    lit("midpipe_l", int'(bus.AUD_L), 0);
    lit("midpipe_ferr", int'(bus.FRAME_ERR), 0);
    frame(6, 10, 10, 0);
    idle(4); #1;
    lit("post_reset_silent", int'(bus.AUD_VALID), 0);
    frame(6, 10, 10, 400);
    idle(4); #1;
`ifndef MD_AUDIO_LPF_EN
    lit("psg_add_l", int'(bus.AUD_L), 1060);
`endif
    idle(4);
    chk("queue_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_audio_mixer.md
Name: md_audio_mixer

Overview:
- Downstream consumer of the FC1004 audio outputs.
- Takes the time-multiplexed YM3438 channel outputs (MOL/MOR, one channel per slot) and the VDP PSG sum (PSG[15:0]).
- Accumulates one full FM channel cycle, adds the scaled PSG, saturates, and emits one stereo 16-bit signed PCM sample per FM cycle with a valid strobe.
- Sits between the fc1004 top and the board-level audio sink.

Parameters:
- FM_SLOTS, 6, number of channel slots per FM output cycle.
- FM_SHIFT, 4, left shift applied to the FM channel sum.
- PSG_SHIFT, 2, right shift applied to the unsigned PSG sum.
- LPF_SHIFT, 3, IIR coefficient shift; used only with MD_AUDIO_LPF_EN.

Ports:
- MCLK  in  1  master clock; all state rises on posedge.
- RESET  in  1  asynchronous, active-high reset.
- MOL  in  9  FM left channel value, two's-complement signed.
- MOR  in  9  FM right channel value, two's-complement signed.
- FM_SLOT  in  1  one-MCLK pulse; MOL/MOR are valid this cycle.
- FM_SYNC  in  1  marks slot 0; only meaningful together with FM_SLOT.
- PSG  in  16  unsigned PSG sum.
- AUD_L  out  16  signed left sample.
- AUD_R  out  16  signed right sample.
- AUD_VALID  out  1  one-MCLK pulse per new sample.
- FRAME_ERR  out  1  sticky: slot count between syncs differed from FM_SLOTS.

Behaviour:
- Reset (asynchronous, immediate): AUD_L=0, AUD_R=0, AUD_VALID=0, FRAME_ERR=0. Accumulators, slot counter, pipeline and LPF state clear. The primed flag clears.
- Slot with FM_SLOT=1 and FM_SYNC=0: acc_L += sext(MOL), acc_R += sext(MOR). Accumulators are 13-bit signed, so no overflow for FM_SLOTS≤16. slot_cnt increments, saturating at 15.
- Sync slot with FM_SLOT=1 and FM_SYNC=1, at cycle T:
  - done_L/R <= acc_L/R (the previous cycle's sum).
  - acc_L/R <= sext(MOL/MOR); the current sample starts the new cycle.
  - psg_q <= PSG.
  - If primed and slot_cnt != FM_SLOTS, set FRAME_ERR.
  - slot_cnt <= 1; primed <= 1.
  - A mix request is raised only if primed was already 1. The first sync after reset produces no output.
- FM_SYNC with FM_SLOT=0: ignored.
- Pipeline:
  - T+1: mix_X = (done_X <<< FM_SHIFT) + ({1'b0,psg_q} >> PSG_SHIFT), computed in 19-bit signed and registered.
  - T+2: saturate to [-32768, 32767], drive AUD_L/AUD_R, pulse AUD_VALID high for exactly one cycle.
  - Latency from the sync strobe to AUD_VALID is 2 MCLK.
- AUD_L/AUD_R hold their value between valid pulses.
- Back-to-back syncs (FM_SYNC on consecutive FM_SLOT pulses) are legal:
  - Each sync emits a sample.
  - FRAME_ERR is set because slot_cnt=1.
  - The pipeline is fully pipelined and drops no sync.
- FRAME_ERR clears only on RESET.
- Reset mid-pipeline: pending samples are discarded and AUD_VALID does not fire.

Optional Feature:
- Macro: MD_AUDIO_LPF_EN.
- When defined: an extra stage at T+3 computes y_X += (sat_X - y_X) >>> LPF_SHIFT, using a 20-bit signed state (16 integer + 4 fraction). AUD_X = y_X integer part. AUD_VALID moves to T+3, so latency is 3. Filter state resets to 0.
- When undefined: no filter; latency is 2.

Decomposition:
- Package md_audio_pkg holds:
  - width constants: FM_W=9, ACC_W=13, MIX_W=19, PCM_W=16;
  - PCM_MAX/PCM_MIN;
  - typedef pcm_t (signed 16-bit).
- One sub-module, md_audio_sat: combinational MIX_W→PCM_W saturator, instantiated once per channel.
- The LPF stays inline under the macro.

Test Plan:
- Reset, then a sync, then 5 slots of MOL=MOR=+10, then a second sync: first sync gives no AUD_VALID; second sync gives AUD_VALID 2 cycles later with AUD_L=AUD_R=(60<<4)+(PSG>>2). With PSG=0 that is 960. FRAME_ERR=0.
- 6 slots with MOL=+255, MOR=-256 and PSG=0xFFFF: AUD_L = 1530·16 + 16383 = 40863, saturates to 32767. AUD_R = -24576 + 16383 = -8193.
- Drive 4 slots between syncs: sample still emitted, FRAME_ERR=1 and stays 1 through later correct 6-slot cycles until RESET.
- Assert RESET one cycle after a sync strobe (mid-pipeline): AUD_VALID never pulses, all outputs 0. The next first sync after release emits nothing.
- FM_SYNC=1 with FM_SLOT=0: no accumulation, no output, no FRAME_ERR change.
- MD_AUDIO_LPF_EN build with a step from 0 to a constant 960 sample: AUD_VALID latency is 3. Outputs rise monotonically: 120, 225, 316, ... converging to 960 (±1 LSB).
